// File: rtl/link_frame_tx_if.sv
// Request strobes and UART line status for link_frame_tx.
interface link_frame_tx_if;
  logic       send;
  logic [1:0] dir;
  logic       seed_rdy;
  logic [4:0] seed_x;
  logic [4:0] seed_y;
  logic       start_req;
  logic       tx;
  logic       busy;
  logic [7:0] frames_sent;

  modport master (
    output send, dir, seed_rdy, seed_x, seed_y, start_req,
    input  tx, busy, frames_sent
  );

  modport slave (
    input  send, dir, seed_rdy, seed_x, seed_y, start_req,
    output tx, busy, frames_sent
  );
endinterface

// File: rtl/link_frame_tx.sv
// Frame transmitter: queues START/SEED/DIR requests (one slot each) and sends
// them as 8N1 UART frames, START > SEED > DIR, with a stop-level gap between
// the bytes of a multi-byte frame.
module link_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 651,
  parameter int unsigned IDLE_GAP     = 2
) (
  input  logic           clk,
  input  logic           rst,
  link_frame_tx_if.slave lnk
);

  localparam int unsigned GAP_CLKS = (IDLE_GAP == 0) ? 1 : IDLE_GAP * CLKS_PER_BIT;
  localparam int unsigned CNT_MAX  = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND_BYTE, S_GAP} seq_t;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_t;

  seq_t          seq_q, seq_d;
  bit_t          bit_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q, byte1_q;
  logic          more_q;
  logic          tx_q, busy_q, busy_d;
  logic [7:0]    frames_q;

  logic          start_pend_q, seed_pend_q, dir_pend_q;
  logic          start_pend_d, seed_pend_d, dir_pend_d;
  logic [4:0]    sx_q, sy_q, sx_d, sy_d;
  logic [1:0]    dir_q, dir_d;

  logic          any_pend, sel_start, sel_seed, sel_dir;
  logic          bit_end, byte_done, frame_done, load;
  logic [7:0]    frm_b0, frm_b1;
  logic          frm_two;

  assign any_pend   = start_pend_q | seed_pend_q | dir_pend_q;
  assign sel_start  = start_pend_q;
  assign sel_seed   = ~start_pend_q & seed_pend_q;
  assign sel_dir    = ~start_pend_q & ~seed_pend_q & dir_pend_q;
  assign bit_end    = (cnt_q == '0);
  assign byte_done  = (seq_q == S_SEND_BYTE) && (bit_q == B_STOP) && bit_end;
  assign frame_done = byte_done && !more_q;
  // A pending frame is loaded directly at the last stop bit so that
  // back-to-back frames have no idle cycles between them.
  assign load       = (seq_q == S_LOAD) || (frame_done && any_pend);

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) seq_q <= S_IDLE;
    else     seq_q <= seq_d;
  end

  // Sequencer next-state logic
  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      S_IDLE:      if (any_pend) seq_d = S_LOAD;
      S_LOAD:      seq_d = S_SEND_BYTE;
      S_SEND_BYTE: begin
        if (byte_done) begin
          if (more_q)        seq_d = (IDLE_GAP == 0) ? S_SEND_BYTE : S_GAP;
          else if (any_pend) seq_d = S_SEND_BYTE;
          else               seq_d = S_IDLE;
        end
      end
      S_GAP:       if (bit_end) seq_d = S_SEND_BYTE;
      default:     seq_d = S_IDLE;
    endcase
  end

  // Request flags, payloads, frame selection and busy
  always_comb begin
    start_pend_d = start_pend_q;
    seed_pend_d  = seed_pend_q;
    dir_pend_d   = dir_pend_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    dir_d        = dir_q;
    if (load) begin
      if (sel_start)     start_pend_d = 1'b0;
      else if (sel_seed) seed_pend_d  = 1'b0;
      else if (sel_dir)  dir_pend_d   = 1'b0;
    end
    if (lnk.start_req) start_pend_d = 1'b1;
    if (lnk.seed_rdy) begin
      seed_pend_d = 1'b1;
      sx_d        = lnk.seed_x;
      sy_d        = lnk.seed_y;
    end
    if (lnk.send) begin
      dir_pend_d = 1'b1;
      dir_d      = lnk.dir;
    end
    frm_b0  = {6'b000000, dir_q};
    frm_b1  = '0;
    frm_two = 1'b0;
    if (sel_start) begin
      frm_b0 = 8'h80;
    end else if (sel_seed) begin
      frm_b0  = {3'b010, sx_q};
      frm_b1  = {3'b011, sy_q};
      frm_two = 1'b1;
    end
    busy_d = (seq_d != S_IDLE) || start_pend_d || seed_pend_d || dir_pend_d;
  end

  // Request registers, busy and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      start_pend_q <= 1'b0;
      seed_pend_q  <= 1'b0;
      dir_pend_q   <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
      dir_q        <= '0;
      busy_q       <= 1'b0;
      frames_q     <= '0;
    end else begin
      start_pend_q <= start_pend_d;
      seed_pend_q  <= seed_pend_d;
      dir_pend_q   <= dir_pend_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      if (frame_done) frames_q <= frames_q + 8'd1;
    end
  end

  // Bit engine: start/data/stop timing, inter-byte gap and registered tx
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q   <= B_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      byte1_q <= '0;
      more_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (load) begin
      shreg_q <= frm_b0;
      byte1_q <= frm_b1;
      more_q  <= frm_two;
      bit_q   <= B_START;
      cnt_q   <= BIT_LAST;
      idx_q   <= '0;
      tx_q    <= 1'b0;
    end else if (seq_q == S_SEND_BYTE) begin
      if (!bit_end) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        case (bit_q)
          B_START: begin
            bit_q <= B_DATA;
            idx_q <= '0;
            cnt_q <= BIT_LAST;
            tx_q  <= shreg_q[0];
          end
          B_DATA: begin
            cnt_q <= BIT_LAST;
            if (idx_q == 3'd7) begin
              bit_q <= B_STOP;
              tx_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end
          B_STOP: begin
            if (more_q) begin
              shreg_q <= byte1_q;
              more_q  <= 1'b0;
              if (IDLE_GAP == 0) begin
                bit_q <= B_START;
                cnt_q <= BIT_LAST;
                tx_q  <= 1'b0;
              end else begin
                bit_q <= B_IDLE;
                cnt_q <= GAP_LAST;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_q <= B_IDLE;
              tx_q  <= 1'b1;
            end
          end
          default: begin
            bit_q <= B_IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end else if (seq_q == S_GAP) begin
      if (!bit_end) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        bit_q <= B_START;
        cnt_q <= BIT_LAST;
        idx_q <= '0;
        tx_q  <= 1'b0;
      end
    end
  end

  assign lnk.tx          = tx_q;
  assign lnk.busy        = busy_q;
  assign lnk.frames_sent = frames_q;

endmodule

// File: tb/tb_link_frame_tx.sv
// Directed bench for link_frame_tx: a UART monitor decodes tx and checks each
// byte and its start cycle against a scoreboard queue filled by the stimulus.
module tb_link_frame_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         t;   // expected first start-bit cycle, -1 = don't care
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  logic mon_en = 1'b1;
  exp_t exp_q[$];
  logic [7:0] exp_frames = 8'd0;

  link_frame_tx_if lnk ();

  link_frame_tx #(.CLKS_PER_BIT(CPB), .IDLE_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic [1:0] d, input logic sr,
                        input logic [4:0] sx, input logic [4:0] sy, input logic st);
    lnk.send      = s;
    lnk.dir       = d;
    lnk.seed_rdy  = sr;
    lnk.seed_x    = sx;
    lnk.seed_y    = sy;
    lnk.start_req = st;
  endtask

  task automatic push(input logic [7:0] b, input int t);
    exp_t e;
    e.b = b;
    e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((lnk.busy !== 1'b0 || exp_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", {31'b0, lnk.busy}, 32'd0);
  endtask

  // UART monitor: samples mid-bit, compares against the scoreboard front
  initial begin : monitor
    int st;
    logic [7:0] got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && lnk.tx === 1'b0) begin
        st = cyc;
        wait_cyc(st + 2);
        check("start_bit", {31'b0, lnk.tx}, 32'd0);
        for (int k = 0; k < 8; k++) begin
          wait_cyc(st + 6 + 4 * k);
          got[k] = lnk.tx;
        end
        wait_cyc(st + 38);
        check("stop_bit", {31'b0, lnk.tx}, 32'd1);
        vecs++;
        assert (exp_q.size() != 0) else begin
          errs++;
          $error("FAIL unexpected_byte: observed byte %0h expected no byte", got);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte", {24'b0, got}, {24'b0, e.b});
          if (e.t >= 0) check("start_cycle", st, e.t);
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic seen_low, seen_busy;
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, lnk.tx}, 32'd1);
    check("rst_busy", {31'b0, lnk.busy}, 32'd0);
    check("rst_frames", {24'b0, lnk.frames_sent}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single DIR frame, latency and busy/frames timing
    set_in(1'b1, 2'b11, 1'b0, 5'd0, 5'd0, 1'b0);
    n = cyc + 1;
    push(8'h03, n + 2);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 1);
    check("load_tx_high", {31'b0, lnk.tx}, 32'd1);
    check("busy_after_req", {31'b0, lnk.busy}, 32'd1);
    wait_cyc(n + 41);
    check("busy_in_stop", {31'b0, lnk.busy}, 32'd1);
    wait_cyc(n + 42);
    exp_frames = exp_frames + 8'd1;
    check("busy_fall", {31'b0, lnk.busy}, 32'd0);
    check("frames_dir", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});
    wait_idle();

    // SEED frame: two bytes separated by an 8-cycle gap
    set_in(1'b0, 2'd0, 1'b1, 5'd7, 5'd20, 1'b0);
    n = cyc + 1;
    push(8'h47, n + 2);
    push(8'h74, n + 50);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 46);
    check("gap_tx_high", {31'b0, lnk.tx}, 32'd1);
    wait_cyc(n + 90);
    exp_frames = exp_frames + 8'd1;
    check("frames_seed", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});
    wait_idle();

    // simultaneous requests: priority order, back-to-back
    set_in(1'b1, 2'b10, 1'b1, 5'd3, 5'd9, 1'b1);
    n = cyc + 1;
    push(8'h80, n + 2);
    push(8'h43, n + 42);
    push(8'h69, n + 90);
    push(8'h02, n + 130);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 129);
    check("busy_between_frames", {31'b0, lnk.busy}, 32'd1);
    wait_idle();
    exp_frames = exp_frames + 8'd3;
    check("frames_prio", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});

    // DIR request overwritten while SEED frame is on the line
    set_in(1'b0, 2'd0, 1'b1, 5'd31, 5'd0, 1'b0);
    n = cyc + 1;
    push(8'h5F, n + 2);
    push(8'h60, n + 50);
    push(8'h01, n + 90);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 9);
    set_in(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 19);
    set_in(1'b1, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_idle();
    exp_frames = exp_frames + 8'd2;
    check("frames_overwrite", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});

    // DIR strobes on three consecutive cycles: overwrite, then re-arm at selection
    set_in(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    n = cyc + 1;
    push(8'h01, n + 2);
    push(8'h02, n + 42);
    @(negedge clk);
    set_in(1'b1, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 2'd2, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_idle();
    exp_frames = exp_frames + 8'd2;
    check("frames_rearm", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});

    // run DIR frames until the counter wraps to zero
    while (exp_frames != 8'd0) begin
      set_in(1'b1, exp_frames[1:0], 1'b0, 5'd0, 5'd0, 1'b0);
      push({6'b0, exp_frames[1:0]}, -1);
      @(negedge clk);
      set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
      wait_idle();
      exp_frames = exp_frames + 8'd1;
      if (exp_frames == 8'd255 || exp_frames == 8'd0)
        check("frames_wrap", {24'b0, lnk.frames_sent}, {24'b0, exp_frames});
    end

    // reset during data bit 3, with strobes coincident with reset
    mon_en = 1'b0;
    set_in(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    n = cyc + 1;
    @(negedge clk);
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    wait_cyc(n + 18);
    check("bit3_low", {31'b0, lnk.tx}, 32'd0);
    rst = 1'b1;
    set_in(1'b1, 2'd3, 1'b1, 5'd1, 5'd1, 1'b1);
    @(negedge clk);
    check("abort_tx", {31'b0, lnk.tx}, 32'd1);
    check("abort_busy", {31'b0, lnk.busy}, 32'd0);
    check("abort_frames", {24'b0, lnk.frames_sent}, 32'd0);
    rst = 1'b0;
    set_in(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    seen_low = 1'b0;
    seen_busy = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (lnk.tx !== 1'b1) seen_low = 1'b1;
      if (lnk.busy !== 1'b0) seen_busy = 1'b1;
    end
    check("post_rst_quiet_tx", {31'b0, seen_low}, 32'd0);
    check("post_rst_quiet_busy", {31'b0, seen_busy}, 32'd0);
    check("post_rst_frames", {24'b0, lnk.frames_sent}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
